// File: rtl/forward_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : forward_scoreboard
// Description : Bypass-source select and load-use stall unit for the ID stage.
//               Optional stall counter enabled by FWD_STALL_CNT_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module forward_scoreboard #(
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int SEL_W   = $clog2(DEPTH+1)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_ready,
    input  logic                     flush,
    input  logic                     id_valid,
    input  logic                     id_regwrite,
    input  logic                     id_is_load,
    input  logic [2:0]               id_destreg,
    input  logic [NUM_SRC-1:0]       src_valid,
    input  logic [3*NUM_SRC-1:0]     src_reg,
    output logic [SEL_W*NUM_SRC-1:0] fwd_sel,
    output logic                     stall
`ifdef FWD_STALL_CNT_EN
    ,
    output logic [15:0]              stall_count
`endif
);

    // Entry k holds the instruction currently in stage k (1 = EX).
    logic [DEPTH:1] r_valid;
    logic [DEPTH:1] r_regwrite;
    logic [DEPTH:1] r_is_load;
    logic [2:0]     r_dest [1:DEPTH];

    logic                     w_hazard;
    logic                     w_push_valid;
    logic [SEL_W*NUM_SRC-1:0] w_fwd_sel;

    // Scan oldest to youngest so the youngest matching stage overwrites.
    always_comb begin
        w_fwd_sel = '0;
        w_hazard  = 1'b0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (src_valid[i]) begin
                for (int k = DEPTH; k >= 1; k--) begin
                    if (r_valid[k] && r_regwrite[k] && (r_dest[k] == src_reg[3*i +: 3])) begin
                        w_fwd_sel[SEL_W*i +: SEL_W] = SEL_W'(k);
                    end
                end
                if (r_valid[1] && r_regwrite[1] && r_is_load[1] &&
                    (r_dest[1] == src_reg[3*i +: 3])) begin
                    w_hazard = 1'b1;
                end
            end
        end
    end

    assign fwd_sel      = w_fwd_sel;
    assign stall        = id_valid & mem_ready & ~flush & w_hazard;
    assign w_push_valid = id_valid & ~flush & ~stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_valid    <= '0;
            r_regwrite <= '0;
            r_is_load  <= '0;
            for (int k = 1; k <= DEPTH; k++) begin
                r_dest[k] <= '0;
            end
        end else if (mem_ready) begin
            for (int k = DEPTH; k >= 2; k--) begin
                r_valid[k]    <= r_valid[k-1];
                r_regwrite[k] <= r_regwrite[k-1];
                r_is_load[k]  <= r_is_load[k-1];
                r_dest[k]     <= r_dest[k-1];
            end
            r_valid[1]    <= w_push_valid;
            r_regwrite[1] <= id_regwrite;
            r_is_load[1]  <= id_is_load;
            r_dest[1]     <= id_destreg;
            // Flush also squashes the instruction moving from EX into MEM.
            if (flush) begin
                r_valid[2] <= 1'b0;
            end
        end
    end

`ifdef FWD_STALL_CNT_EN
    logic [15:0] r_stall_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_count <= '0;
        end else if (stall && (r_stall_count != 16'hFFFF)) begin
            r_stall_count <= r_stall_count + 16'd1;
        end
    end

    assign stall_count = r_stall_count;
`endif

endmodule
`default_nettype wire

// File: tb/tb_forward_scoreboard.sv
`default_nettype none
// ============================================================================
// Module      : tb_forward_scoreboard
// Description : Directed vector bench for forward_scoreboard (NUM_SRC=2, DEPTH=3).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_forward_scoreboard;

    logic       clk;
    logic       rst_n;
    logic       mem_ready;
    logic       flush;
    logic       id_valid;
    logic       id_regwrite;
    logic       id_is_load;
    logic [2:0] id_destreg;
    logic [1:0] src_valid;
    logic [5:0] src_reg;
    logic [3:0] fwd_sel;
    logic       stall;
`ifdef FWD_STALL_CNT_EN
    logic [15:0] stall_count;
`endif

    forward_scoreboard #(.NUM_SRC(2), .DEPTH(3)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .mem_ready   (mem_ready),
        .flush       (flush),
        .id_valid    (id_valid),
        .id_regwrite (id_regwrite),
        .id_is_load  (id_is_load),
        .id_destreg  (id_destreg),
        .src_valid   (src_valid),
        .src_reg     (src_reg),
        .fwd_sel     (fwd_sel),
        .stall       (stall)
`ifdef FWD_STALL_CNT_EN
        ,
        .stall_count (stall_count)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic       mr, fl, iv, rw, ld;
        logic [2:0] dst;
        logic [1:0] sv;
        logic [2:0] s1, s0;
        logic       chk_sel;
        logic [1:0] e1, e0;
        logic       est;
    } vec_t;

    vec_t vecs[$];
    int   checks   = 0;
    int   failures = 0;
    int   exp_cnt  = 0;

    function automatic vec_t mk(int mr, int fl, int iv, int rw, int ld, int dst, int sv,
                                int s1, int s0, int chk, int e1, int e0, int est);
        vec_t v;
        v.mr = 1'(mr); v.fl = 1'(fl); v.iv = 1'(iv); v.rw = 1'(rw); v.ld = 1'(ld);
        v.dst = 3'(dst); v.sv = 2'(sv); v.s1 = 3'(s1); v.s0 = 3'(s0);
        v.chk_sel = 1'(chk); v.e1 = 2'(e1); v.e0 = 2'(e0); v.est = 1'(est);
        return v;
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic drive(input logic mr, input logic fl, input logic iv, input logic rw,
                         input logic ld, input logic [2:0] dst, input logic [1:0] sv,
                         input logic [2:0] s1, input logic [2:0] s0);
        mem_ready = mr; flush = fl; id_valid = iv; id_regwrite = rw;
        id_is_load = ld; id_destreg = dst; src_valid = sv; src_reg = {s1, s0};
    endtask

    task automatic chk_cnt(input string name, input int exp);
`ifdef FWD_STALL_CNT_EN
        chk(name, stall_count, 16'(exp));
`endif
    endtask

    initial begin
        //              mr fl iv rw ld dst sv  s1 s0 chk e1 e0 st
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3, 1, 0, 1, 0, 0, 0)); // idle after reset
        vecs.push_back(mk(1, 0, 1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0)); // ADD R1
        vecs.push_back(mk(1, 0, 1, 1, 0, 2, 3, 3, 1, 1, 0, 1, 0)); // ADD R2,R1,R3
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 3, 2, 1, 1, 1, 2, 0)); // R1 now in MEM
        vecs.push_back(mk(1, 0, 1, 1, 1, 4, 1, 0, 1, 1, 0, 3, 0)); // LDR R4, R1 in WB
        vecs.push_back(mk(1, 0, 1, 1, 0, 5, 3, 4, 4, 0, 0, 0, 1)); // ADD R5,R4,R4 stalls
        vecs.push_back(mk(1, 0, 1, 1, 0, 5, 3, 4, 4, 1, 2, 2, 0)); // retry: both from MEM
        vecs.push_back(mk(1, 0, 1, 1, 0, 2, 1, 0, 4, 1, 0, 3, 0)); // write R2
        vecs.push_back(mk(1, 0, 1, 1, 0, 3, 1, 0, 2, 1, 0, 1, 0)); // write R3
        vecs.push_back(mk(1, 0, 1, 1, 0, 2, 3, 2, 5, 1, 2, 3, 0)); // write R2 again
        vecs.push_back(mk(1, 0, 1, 1, 0, 0, 1, 2, 2, 1, 0, 1, 0)); // R2 in 1&3, imm op1; writes R0
        vecs.push_back(mk(1, 0, 1, 0, 0, 0, 3, 3, 0, 1, 3, 1, 0)); // R0 forwarded
        vecs.push_back(mk(1, 0, 1, 1, 1, 6, 0, 0, 0, 1, 0, 0, 0)); // LDR R6
        vecs.push_back(mk(0, 0, 1, 1, 0, 7, 3, 0, 6, 1, 3, 1, 0)); // frozen x3
        vecs.push_back(mk(0, 0, 1, 1, 0, 7, 3, 0, 6, 1, 3, 1, 0));
        vecs.push_back(mk(0, 0, 1, 1, 0, 7, 3, 0, 6, 1, 3, 1, 0));
        vecs.push_back(mk(1, 0, 1, 1, 0, 7, 3, 0, 6, 0, 0, 0, 1)); // unfrozen: stall
        vecs.push_back(mk(1, 0, 1, 1, 0, 7, 3, 0, 6, 1, 0, 2, 0)); // R0 aged out
        vecs.push_back(mk(1, 0, 1, 1, 1, 1, 0, 0, 0, 1, 0, 0, 0)); // LDR R1
        vecs.push_back(mk(1, 1, 1, 1, 0, 3, 3, 7, 1, 1, 2, 1, 0)); // flush beats stall
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 3, 7, 1, 1, 3, 0, 0)); // stages 1-2 squashed
        vecs.push_back(mk(1, 0, 1, 1, 1, 2, 0, 0, 0, 1, 0, 0, 0)); // LDR R2
        vecs.push_back(mk(1, 0, 0, 0, 0, 0, 1, 0, 2, 1, 0, 1, 0)); // no stall without id_valid
        vecs.push_back(mk(1, 0, 1, 1, 1, 3, 0, 0, 0, 1, 0, 0, 0)); // LDR R3
        vecs.push_back(mk(0, 1, 1, 1, 0, 4, 3, 2, 3, 1, 3, 1, 0)); // flush ignored while frozen
        vecs.push_back(mk(1, 0, 1, 1, 0, 4, 3, 2, 3, 0, 0, 0, 1)); // load R3 still in EX
        vecs.push_back(mk(1, 0, 1, 1, 0, 4, 3, 2, 3, 1, 0, 2, 0));

        rst_n = 1'b0;
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        foreach (vecs[n]) begin
            if (n != 0) @(negedge clk);
            drive(vecs[n].mr, vecs[n].fl, vecs[n].iv, vecs[n].rw, vecs[n].ld,
                  vecs[n].dst, vecs[n].sv, vecs[n].s1, vecs[n].s0);
            #2;
            chk($sformatf("vec%0d stall", n), 16'(stall), 16'(vecs[n].est));
            if (vecs[n].chk_sel) begin
                chk($sformatf("vec%0d sel0", n), 16'(fwd_sel[1:0]), 16'(vecs[n].e0));
                chk($sformatf("vec%0d sel1", n), 16'(fwd_sel[3:2]), 16'(vecs[n].e1));
            end
            chk_cnt($sformatf("vec%0d stall_count", n), exp_cnt);
            if (vecs[n].est) exp_cnt++;
        end

        // Reset asserted in the middle of a load-use stall.
        @(negedge clk);
        drive(1, 0, 1, 1, 1, 5, 0, 0, 0);
        @(negedge clk);
        drive(1, 0, 1, 1, 0, 6, 1, 0, 5);
        #2;
        chk("pre_reset stall", 16'(stall), 16'd1);
        chk_cnt("pre_reset stall_count", exp_cnt);
        #1 rst_n = 1'b0;
        #1;
        chk("reset stall", 16'(stall), 16'd0);
        chk("reset fwd_sel", 16'(fwd_sel), 16'd0);
        chk_cnt("reset stall_count", 0);
        @(negedge clk);
        chk("reset_hold stall", 16'(stall), 16'd0);
        chk("reset_hold fwd_sel", 16'(fwd_sel), 16'd0);

        // First advance after release pushes normally; R0 write, then reader.
        rst_n = 1'b1;
        drive(1, 0, 1, 1, 0, 0, 3, 5, 5);
        #2;
        chk("post_reset fwd_sel", 16'(fwd_sel), 16'd0);
        chk("post_reset stall", 16'(stall), 16'd0);
        @(negedge clk);
        drive(1, 0, 1, 0, 0, 0, 3, 5, 0);
        #2;
        chk("r0 sel0", 16'(fwd_sel[1:0]), 16'd1);
        chk("r0 sel1", 16'(fwd_sel[3:2]), 16'd0);
        chk_cnt("post_reset stall_count", 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/forward_scoreboard.md
# forward_scoreboard

Parametrised forwarding and hazard unit for the pipelined LC-3b core. It tracks every in-flight register write from EX through a configurable number of downstream stages, and returns a bypass-source select for each decode-stage source operand. It also detects load-use hazards and raises a one-cycle stall. It sits beside the ID stage and replaces per-operand, per-opcode forwarding logic: decode decides operand validity, this block decides where the value comes from.

## Interface
Parameters:
- NUM_SRC, 2: number of decode source operands checked per cycle.
- DEPTH, 3: tracked stages after ID (stage 1 = EX, 2 = MEM, 3 = WB, …); minimum 2.
- SEL_W, $clog2(DEPTH+1): width of each select field.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- mem_ready  in  1  0 freezes the whole pipeline; no shift, no stall or flush action.
- flush  in  1  squash ID and EX, honoured only when mem_ready=1.
- id_valid  in  1  decode holds a real instruction.
- id_regwrite  in  1  decode instruction writes a register.
- id_is_load  in  1  decode instruction's result is available only at end of MEM (LDB/LDW/LDI/LDR).
- id_destreg  in  3  decode destination register.
- src_valid  in  NUM_SRC  per-operand "reads a register" (0 for immediate-mode or unused operands).
- src_reg  in  3*NUM_SRC  packed source register numbers; operand i at bits [3i+2:3i].
- fwd_sel  out  SEL_W*NUM_SRC  per-operand source: 0 = register file, k = stage k result.
- stall  out  1  load-use hazard; hold PC/IF/ID, inject bubble into EX.
- stall_count  out  16  present only with FWD_STALL_CNT_EN.

## Operation
- State is an entry per stage 1..DEPTH: {valid, regwrite, is_load, destreg}.
- An entry "writes r" when valid & regwrite & destreg==r.
- R0 is architectural in LC-3b and is forwarded like any other register. There is no R0 exclusion.
- Select for operand i:
  - If src_valid[i]=0, the select is 0.
  - Otherwise it is the lowest k whose entry writes src_reg[i] (youngest wins).
  - If no entry matches, the select is 0.
- Stall condition: id_valid & mem_ready & some operand i with src_valid[i], whose youngest match is stage 1 with is_load=1.
  - Several hazardous operands still give a single stall.
  - fwd_sel is don't-care while stall=1.
- Advance happens when mem_ready=1. Stage k+1 ← stage k for k ≥ 1, and stage 1 ← push entry. The push entry is:
  - Bubble (valid=0) if flush, stall, or !id_valid.
  - Otherwise {1, id_regwrite, id_is_load, id_destreg}.
- Flush (with advance) makes both stage 1 and stage 2 bubbles. Stages ≥ 3 shift normally.
  - Flush has priority over stall. stall is forced to 0 while flush=1.
- Freeze (mem_ready=0): every entry holds its value.
  - stall=0.
  - fwd_sel is still computed from held state.
- The oldest entry (stage DEPTH) is discarded on advance.

## Timing
- fwd_sel and stall are combinational from current entries plus same-cycle ID inputs.
- Entry updates happen on the rising clk edge.
- A load hazard costs exactly one stall cycle. On the next cycle the load sits in stage 2, and the operand selects 2.
- rst_n low at any time, including mid-stall or mid-freeze:
  - All entries go invalid immediately.
  - fwd_sel = 0 and stall = 0 while rst_n is low and after release.
  - stall_count = 0.
- The first advance after reset release pushes normally.

## Configuration
- FWD_STALL_CNT_EN defined:
  - The stall_count port exists.
  - It increments by 1 each clock in which stall=1 and saturates at 16'hFFFF.
  - It resets to 0 on rst_n.
- Undefined: the port and the counter are absent. All other behaviour is identical.

## Test plan
- ADD R1 then ADD R2,R1,R3 back-to-back -> second instr fwd_sel[0]=1, stall=0; one cycle later with R1 still in stage 2, a reader gets 2.
- LDR R4 then ADD R5,R4,R4 -> stall=1 for exactly one cycle. Next cycle both operands select 2, stall=0; stall_count goes 0→1.
- Writes to R2 in stages 1 and 3, reader of R2 -> select 1. Immediate-mode AND with src_valid[1]=0 reading R2 -> select 0 for operand 1.
- LDR R6 in stage 1 with mem_ready=0 for 3 cycles -> stall=0 and entries unchanged throughout. Once mem_ready=1, dependent reader gets stall=1.
- flush with pending LDR R1 in stage 1 and dependent reader in ID -> stall=0. Next cycle stages 1–2 invalid and reader of R1 gets select 0.
- Assert rst_n=0 during a stall cycle -> stall drops immediately, all selects 0, stall_count=0. Instruction writing R0 then reader of R0 -> select 1 (R0 not excluded).
